spi_slave_tx_feeder: RTL

Upstream companion of the SPI slave transmit shifter, in the same sclk domain. It pulls words from the (already clock-domain-crossed) TX FIFO and presents them to the shifter with a matching bit-count target. It reloads back-to-back on each word-done pulse, so a multi-word read burst shifts out with no gap bits. On FIFO underrun it substitutes a fill word and flags the error.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_slave_tx_feeder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_pkg
// Brief    : Shared types and constants for the SPI slave datapath.
// Revision : 1.0
// ============================================================================
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_feed_state_e;

    // word_bits encodings (bits per word minus one)
    localparam logic [7:0] c_word_bits_byte = 8'd7;
    localparam logic [7:0] c_word_bits_word = 8'd31;

endpackage
`default_nettype wire

// File: rtl/spi_slave_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_tx_feeder
// Brief    : Pulls TX FIFO words and reloads the SPI transmit shifter gaplessly.
// Revision : 1.0
// ============================================================================
module spi_slave_tx_feeder
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            word_bits,
    input  logic [LEN_WIDTH-1:0]  num_words,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic [7:0]            tx_counter,
    output logic                  tx_counter_upd,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  underrun
);

    tx_feed_state_e        r_state;
    tx_feed_state_e        w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [7:0]            r_word_bits;
    logic                  r_busy;
    logic                  r_xfer_done;
    logic                  r_underrun;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic                  w_load;
    logic                  w_last;
    logic                  w_fill;
    logic [DATA_WIDTH-1:0] w_word;

    // A load strobe is suppressed while rst is high so an abort never pops.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (num_words != '0)) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load      = !rst;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (tx_done) begin
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load = !rst;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_fill = w_load && !fifo_valid;
        w_word = fifo_valid ? fifo_data : FILL_WORD;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_word_bits <= '0;
            r_busy      <= 1'b0;
            r_xfer_done <= 1'b0;
            r_underrun  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_xfer_done <= 1'b0;
            if ((r_state == IDLE) && start) begin
                r_underrun <= 1'b0;
                if (num_words == '0) begin
                    r_xfer_done <= 1'b1;
                end else begin
                    r_word_bits <= word_bits;
                    r_remaining <= num_words;
                    r_busy      <= 1'b1;
                end
            end
            if (w_fill) begin
                r_underrun <= 1'b1;
            end
            if (w_load) begin
                r_tx_data <= w_word;
            end
            if ((r_state == SHIFT) && tx_done) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            if (w_last) begin
                r_xfer_done <= 1'b1;
                r_busy      <= 1'b0;
            end
        end
    end

    // tx_data holds the last presented word between load strobes.
    always_comb begin
        tx_data_valid  = w_load;
        tx_counter_upd = w_load;
        fifo_ready     = w_load && fifo_valid;
        tx_data        = w_load ? w_word : r_tx_data;
        tx_counter     = r_word_bits;
        busy           = r_busy;
        xfer_done      = r_xfer_done;
        underrun       = r_underrun || w_fill;
    end

endmodule
`default_nettype wire
